add_accum: RTL and testbench

ADD_ACCUM -- requirements
Module: add_accum

---
 rtl/add_accum_pkg.sv | 14 +
 rtl/add_accum_sat.sv | 39 +++
 rtl/add_accum.sv | 138 +++++++++++++
 tb/tb_add_accum.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_accum_pkg.sv
// add_accum_pkg: shared types and constants for the add_accum block.
//   state_t : batch controller states (IDLE, RUN, DONE)
//   RES_W   : width of one accepted adder result {in_ov, in_sum}
package add_accum_pkg;

    localparam int RES_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add_accum_sat.sv
// add_accum_sat: combinational ACC_W-bit accumulate step.
// Adds a zero-extended RES_W-bit result to the current total and flags
// when the true sum no longer fits in ACC_W bits.
// Build option: define ADD_ACCUM_SAT_EN to clamp the sum at 2^ACC_W-1
// instead of wrapping modulo 2^ACC_W.
// Ports:
//   acc_in  [ACC_W-1:0]  current accumulator value
//   value   [RES_W-1:0]  unsigned result to add
//   sum     [ACC_W-1:0]  next accumulator value (wrapped or clamped)
//   wrap                 true sum exceeded 2^ACC_W-1
module add_accum_sat
    import add_accum_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic [ACC_W-1:0] acc_in,
    input  logic [RES_W-1:0] value,
    output logic [ACC_W-1:0] sum,
    output logic             wrap
);

    logic [ACC_W:0] sum_ext_s;

    // One extra bit holds the carry out that signals overflow of the total.
    always_comb begin
        sum_ext_s = {1'b0, acc_in} + {{(ACC_W + 1 - RES_W){1'b0}}, value};
        wrap      = sum_ext_s[ACC_W];
`ifdef ADD_ACCUM_SAT_EN
        if (sum_ext_s[ACC_W]) begin
            sum = {ACC_W{1'b1}};
        end else begin
            sum = sum_ext_s[ACC_W-1:0];
        end
`else
        sum = sum_ext_s[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/add_accum.sv
// add_accum: batch accumulator for a 4-bit adder with carry output.
// A start pulse opens a batch of N_OPS results; each accepted result
// {in_ov, in_sum} is added to acc, results with in_ov set are counted in
// ov_cnt (saturating), and acc_wrap records any overflow of acc.
// Build option: ADD_ACCUM_SAT_EN (clamp acc instead of wrapping).
// Ports:
//   clk, rst (async, active-low)
//   start            one-cycle pulse, opens a batch from IDLE or DONE
//   in_valid/in_ready  result handshake, ready only while running
//   in_sum[3:0], in_ov adder result
//   busy, done       batch status
//   acc[ACC_W-1:0]   running total
//   ov_cnt[CNT_W-1:0] count of accepted results with in_ov=1
//   acc_wrap         sticky accumulator overflow flag
module add_accum
    import add_accum_pkg::*;
#(
    parameter int ACC_W = 8,
    parameter int CNT_W = 8,
    parameter int N_OPS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_sum,
    input  logic             in_ov,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] acc,
    output logic [CNT_W-1:0] ov_cnt,
    output logic             acc_wrap
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_OPS);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] ov_cnt_r;
    logic [CNT_W-1:0] op_cnt_r;
    logic             acc_wrap_r;
    logic             in_ready_r;
    logic             busy_r;
    logic             done_r;

    logic [RES_W-1:0] value_s;
    logic [ACC_W-1:0] sum_s;
    logic             wrap_s;
    logic             last_s;

    assign value_s = {in_ov, in_sum};
    assign last_s  = ((op_cnt_r + CNT_ONE) == LAST_CNT);

    add_accum_sat #(
        .ACC_W (ACC_W)
    ) u_sat (
        .acc_in (acc_r),
        .value  (value_s),
        .sum    (sum_s),
        .wrap   (wrap_s)
    );

    // Batch FSM, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            acc_r      <= {ACC_W{1'b0}};
            ov_cnt_r   <= {CNT_W{1'b0}};
            op_cnt_r   <= {CNT_W{1'b0}};
            acc_wrap_r <= 1'b0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    // Everything clears on the same edge that opens the batch.
                    if (start) begin
                        state_r    <= RUN;
                        acc_r      <= {ACC_W{1'b0}};
                        ov_cnt_r   <= {CNT_W{1'b0}};
                        op_cnt_r   <= {CNT_W{1'b0}};
                        acc_wrap_r <= 1'b0;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                        done_r     <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                RUN: begin
                    // start is ignored here; only accepted results change state.
                    if (in_valid && in_ready_r) begin
                        acc_r    <= sum_s;
                        op_cnt_r <= op_cnt_r + CNT_ONE;
                        if (wrap_s) begin
                            acc_wrap_r <= 1'b1;
                        end else begin
                            acc_wrap_r <= acc_wrap_r;
                        end
                        if (in_ov && (ov_cnt_r != CNT_MAX)) begin
                            ov_cnt_r <= ov_cnt_r + CNT_ONE;
                        end else begin
                            ov_cnt_r <= ov_cnt_r;
                        end
                        if (last_s) begin
                            state_r    <= DONE;
                            in_ready_r <= 1'b0;
                            busy_r     <= 1'b0;
                            done_r     <= 1'b1;
                        end else begin
                            state_r <= RUN;
                        end
                    end else begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign acc      = acc_r;
    assign ov_cnt   = ov_cnt_r;
    assign acc_wrap = acc_wrap_r;

endmodule

// File: tb/tb_add_accum.sv
// tb_add_accum: self-checking bench for add_accum.
// Two instances share the result bus: dut0 with N_OPS=4, dut1 with N_OPS=9.
// Each driven cycle, a bench model computes the expected post-edge outputs
// of both instances and pushes them to a scoreboard; the test tasks pop and
// compare after the edge.
module tb_add_accum;

    localparam int ACC_W = 8;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       rdy;
        logic       wrap;
        logic [7:0] acc;
        logic [7:0] ov;
    } obs_t;

    typedef struct packed {
        obs_t d1;
        obs_t d0;
    } pair_t;

    logic       clk;
    logic       rst;
    logic       start0, start1;
    logic       in_valid;
    logic [3:0] in_sum;
    logic       in_ov;
    logic       rdy0, rdy1, busy0, busy1, done0, done1, wrap0, wrap1;
    logic [7:0] acc0, acc1, ov0, ov1;

    pair_t obs;
    pair_t e;
    pair_t sb[$];

    int checks = 0;
    int errors = 0;

    // bench model state per instance: 0 idle, 1 run, 2 done
    int m_st[2];
    int m_acc[2];
    int m_ov[2];
    int m_cnt[2];
    bit m_wrap[2];
    int n_ops[2] = '{4, 9};

    add_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W), .N_OPS(4)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .in_valid(in_valid),
        .in_ready(rdy0), .in_sum(in_sum), .in_ov(in_ov), .busy(busy0),
        .done(done0), .acc(acc0), .ov_cnt(ov0), .acc_wrap(wrap0)
    );

    add_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W), .N_OPS(9)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid),
        .in_ready(rdy1), .in_sum(in_sum), .in_ov(in_ov), .busy(busy1),
        .done(done1), .acc(acc1), .ov_cnt(ov1), .acc_wrap(wrap1)
    );

    assign obs = {busy1, done1, rdy1, wrap1, acc1, ov1,
                  busy0, done0, rdy0, wrap0, acc0, ov0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_st[d] = 0; m_acc[d] = 0; m_ov[d] = 0; m_cnt[d] = 0; m_wrap[d] = 1'b0;
        end
    endtask

    task automatic model_step(input int d, input bit s, input bit vld, input logic [4:0] v);
        int sum;
        if (s && m_st[d] != 1) begin
            m_st[d] = 1; m_acc[d] = 0; m_ov[d] = 0; m_cnt[d] = 0; m_wrap[d] = 1'b0;
        end else if (m_st[d] == 1 && vld) begin
            sum = m_acc[d] + int'(v);
            if (sum > 255) begin
                m_wrap[d] = 1'b1;
`ifdef ADD_ACCUM_SAT_EN
                m_acc[d] = 255;
`else
                m_acc[d] = sum - 256;
`endif
            end else begin
                m_acc[d] = sum;
            end
            if (v[4] && m_ov[d] < 255) m_ov[d] = m_ov[d] + 1;
            m_cnt[d] = m_cnt[d] + 1;
            if (m_cnt[d] == n_ops[d]) m_st[d] = 2;
        end
    endtask

    function automatic obs_t model_obs(input int d);
        obs_t o;
        o.busy = (m_st[d] == 1);
        o.done = (m_st[d] == 2);
        o.rdy  = (m_st[d] == 1);
        o.wrap = m_wrap[d];
        o.acc  = m_acc[d][7:0];
        o.ov   = m_ov[d][7:0];
        return o;
    endfunction

    // Drive one cycle of inputs, record expected post-edge outputs, wait past the edge.
    task automatic drive(input bit s0, input bit s1, input bit vld, input logic [4:0] v);
        pair_t p;
        start0 = s0; start1 = s1; in_valid = vld; in_ov = v[4]; in_sum = v[3:0];
        model_step(0, s0, vld, v);
        model_step(1, s1, vld, v);
        p.d0 = model_obs(0);
        p.d1 = model_obs(1);
        sb.push_back(p);
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b0; start0 = 1'b0; start1 = 1'b0; in_valid = 1'b0; in_sum = 4'd0; in_ov = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== '0) begin
            errors++; $display("FAIL reset got %h exp %h", obs, '0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle_valid();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, 5'd31);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL idle_valid got %h exp %h", obs, e); end
        end
    endtask

    task automatic test_basic();
        drive(1'b1, 1'b0, 1'b0, 5'd0);
        e = sb.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL basic_start got %h exp %h", obs, e); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 5'd30);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL basic got %h exp %h", obs, e); end
        end
        checks++;
        if (acc0 !== 8'd120 || ov0 !== 8'd4 || done0 !== 1'b1 || wrap0 !== 1'b0) begin
            errors++; $display("FAIL basic_final got acc=%0d ov=%0d done=%b wrap=%b exp 120 4 1 0",
                                acc0, ov0, done0, wrap0);
        end
        // DONE holds its results while idle cycles pass
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b1, 5'd7);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL done_hold got %h exp %h", obs, e); end
        end
    endtask

    task automatic test_restart();
        drive(1'b1, 1'b0, 1'b0, 5'd0);
        e = sb.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL restart got %h exp %h", obs, e); end
        checks++;
        if (busy0 !== 1'b1 || rdy0 !== 1'b1 || done0 !== 1'b0 || acc0 !== 8'd0 || ov0 !== 8'd0) begin
            errors++; $display("FAIL restart_state got busy=%b rdy=%b done=%b acc=%0d ov=%0d exp 1 1 0 0 0",
                                busy0, rdy0, done0, acc0, ov0);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 5'(i + 1));
            e = sb.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL restart_run got %h exp %h", obs, e); end
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b1, 1'b0, 5'd0);
        e = sb.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL wrap_start got %h exp %h", obs, e); end
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b0, 1'b1, 5'd30);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL wrap got %h exp %h", obs, e); end
        end
        checks++;
`ifdef ADD_ACCUM_SAT_EN
        if (acc1 !== 8'd255 || wrap1 !== 1'b1 || done1 !== 1'b1) begin
            errors++; $display("FAIL wrap_final got acc=%0d wrap=%b done=%b exp 255 1 1", acc1, wrap1, done1);
        end
`else
        if (acc1 !== 8'd14 || wrap1 !== 1'b1 || done1 !== 1'b1) begin
            errors++; $display("FAIL wrap_final got acc=%0d wrap=%b done=%b exp 14 1 1", acc1, wrap1, done1);
        end
`endif
    endtask

    task automatic test_start_in_run();
        bit s [6]      = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        bit vld [6]    = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive(s[i], 1'b0, vld[i], 5'd3);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL start_in_run step%0d got %h exp %h", i, obs, e); end
        end
        checks++;
        if (acc0 !== 8'd12 || done0 !== 1'b1) begin
            errors++; $display("FAIL start_in_run_final got acc=%0d done=%b exp 12 1", acc0, done0);
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 1'b0, 1'b0, 5'd0);
        e = sb.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL midrst_start got %h exp %h", obs, e); end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b1, 5'd31);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL midrst_run got %h exp %h", obs, e); end
        end
        in_valid = 1'b0;
        #1 rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (acc0 !== 8'd0 || busy0 !== 1'b0 || obs !== '0) begin
            errors++; $display("FAIL midrst_async got %h exp %h", obs, '0);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 5'd9);
        e = sb.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL midrst_idle got %h exp %h", obs, e); end
        drive(1'b1, 1'b0, 1'b0, 5'd0);
        e = sb.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL midrst_restart got %h exp %h", obs, e); end
        drive(1'b0, 1'b0, 1'b1, 5'd5);
        e = sb.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL midrst_xfer got %h exp %h", obs, e); end
        checks++;
        if (acc0 !== 8'd5) begin
            errors++; $display("FAIL midrst_final got acc=%0d exp 5", acc0);
        end
        drive(1'b0, 1'b0, 1'b0, 5'd0);
        e = sb.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL midrst_hold got %h exp %h", obs, e); end
    endtask

    initial begin
        test_reset();
        test_idle_valid();
        test_basic();
        test_restart();
        test_wrap();
        test_start_in_run();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
